multi_channel_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 20 ++
 rtl/multi_channel_timer_if.sv | 30 +++
 rtl/timer_channel.sv | 70 +++++++
 rtl/multi_channel_timer.sv | 68 ++++++
 tb/tb_multi_channel_timer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the multi-channel down-counting timer.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a (no handshake; all consumers are strobe driven).
package timer_pkg;

    // Channel FSM encoding, kept as plain vectors so legacy tools can read it.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    localparam int DEF_WIDTH    = 9;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_PRESCALE = 1;

    // Width of an index that can address every channel (never below 1 bit).
    function automatic int chan_idx_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/multi_channel_timer_if.sv
// Bundle between the tick/prescale source and the timer: per-channel control in, expiry/status out.
// Latency: n/a (wiring only); master drives controls, slave (the timer) drives out/busy/count.
// Backpressure: none; start/stop/count_en are single-clock strobes that are always accepted.
interface multi_channel_timer_if
    import timer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
);

    logic                      count_en;
    logic [CHANNELS-1:0]       start;
    logic [CHANNELS-1:0]       stop;
    logic [CHANNELS-1:0]       periodic;
    logic [CHANNELS*WIDTH-1:0] load_value;
    logic [CHANNELS-1:0]       out;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS*WIDTH-1:0] count;

    modport master (
        output count_en, start, stop, periodic, load_value,
        input  out, busy, count
    );

    modport slave (
        input  count_en, start, stop, periodic, load_value,
        output out, busy, count
    );

endinterface

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN FSM, down-counter, reload and mode registers; ports clk/reset, tick, start/stop/periodic/load_value in, out/busy/count out.
// Latency: expiry pulse on out is registered on the edge of the Nth tick after start (load 0: the start edge itself).
// Backpressure: none; priority per clock is reset > start > stop > tick.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] load_value,
    output logic             out,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    state_t           state;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] reload;
    logic             mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            counter <= '0;
            reload  <= '0;
            mode    <= 1'b0;
            out     <= 1'b0;
        end else begin
            out <= 1'b0;
            if (start) begin
                // A tick on this edge is deliberately ignored: counting starts next tick.
                reload  <= load_value;
                counter <= load_value;
                mode    <= periodic;
                if (load_value == '0) begin
                    // Zero load expires immediately, once; never enters RUN so a
                    // periodic zero load cannot turn into a continuous pulse train.
                    state <= ST_IDLE;
                    out   <= 1'b1;
                end else begin
                    state <= ST_RUN;
                end
            end else if (stop) begin
                state <= ST_IDLE;
            end else if (tick && (state == ST_RUN)) begin
                if (counter > WIDTH'(1)) begin
                    counter <= counter - WIDTH'(1);
                end else begin
                    // RUN always holds counter >= 1, so this is the expiry tick.
                    out <= 1'b1;
                    if (mode) begin
                        counter <= reload;
                    end else begin
                        counter <= '0;
                        state   <= ST_IDLE;
                    end
                end
            end
        end
    end

    assign busy  = (state == ST_RUN);
    assign count = counter;

endmodule

// File: rtl/multi_channel_timer.sv
// CHANNELS independent down-counters on a shared tick; ports clk, reset, bus (multi_channel_timer_if.slave). Optional macro TIMER_PRESCALE_EN divides count_en by PRESCALE.
// Latency: out pulse registered on the edge of the Nth tick after start; periodic channels pulse every N ticks.
// Backpressure: none; all controls are strobes accepted every clock.
module multi_channel_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic                   clk,
    input  logic                   reset,
    multi_channel_timer_if.slave   bus
);

    // Out-of-range configurations leave this marker block in the hierarchy.
    if ((CHANNELS < 1) || (CHANNELS > 16) || (PRESCALE < 1)) begin : g_bad_config
    end

    logic tick;

`ifdef TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] ps_cnt;

    // Free-running divider: start does not realign it, so a channel's first
    // decrement may come after fewer than PRESCALE count_en pulses.
    assign tick = bus.count_en && (ps_cnt == PS_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_cnt <= '0;
        end else if (bus.count_en) begin
            ps_cnt <= tick ? '0 : ps_cnt + PW'(1);
        end
    end
`else
    assign tick = bus.count_en;
`endif

    logic [CHANNELS-1:0]       ch_out;
    logic [CHANNELS-1:0]       ch_busy;
    logic [CHANNELS*WIDTH-1:0] ch_count;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .start      (bus.start[i]),
            .stop       (bus.stop[i]),
            .periodic   (bus.periodic[i]),
            .load_value (bus.load_value[i*WIDTH +: WIDTH]),
            .out        (ch_out[i]),
            .busy       (ch_busy[i]),
            .count      (ch_count[i*WIDTH +: WIDTH])
        );
    end

    assign bus.out   = ch_out;
    assign bus.busy  = ch_busy;
    assign bus.count = ch_count;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Self-checking bench for multi_channel_timer: directed table, corner sequences and random traffic vs a deadline-based model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_multi_channel_timer;

    localparam int W   = 9;
    localparam int CH  = 4;
    localparam int PRE = 3;
`ifdef TIMER_PRESCALE_EN
    localparam int PS = PRE;
`else
    localparam int PS = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_channel_timer_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    multi_channel_timer #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(PRE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int pcnt [CH];
    int cyc_num = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: each running channel holds the absolute tick number at
    // which it expires; the visible count is the distance to that deadline.
    bit m_run [CH];
    bit m_mode [CH];
    bit m_pulse [CH];
    int m_period [CH];
    int m_deadline [CH];
    int m_frozen [CH];
    int m_t;
    int m_ce;

    task automatic model_reset();
        m_t  = 0;
        m_ce = 0;
        for (int i = 0; i < CH; i++) begin
            m_run[i] = 0; m_mode[i] = 0; m_pulse[i] = 0;
            m_period[i] = 0; m_deadline[i] = 0; m_frozen[i] = 0;
        end
    endtask

    task automatic model_step(input logic [CH-1:0] st, input logic [CH-1:0] sp,
                              input logic [CH-1:0] per, input logic [CH*W-1:0] lv,
                              input logic ce);
        int t_before;
        int v;
        bit tick;
        t_before = m_t;
        tick = ce && (((m_ce + 1) % PS) == 0);
        if (ce) m_ce++;
        if (tick) m_t++;
        for (int i = 0; i < CH; i++) begin
            m_pulse[i] = 0;
            v = int'(lv[i*W +: W]);
            if (st[i]) begin
                m_mode[i]   = per[i];
                m_period[i] = v;
                if (v == 0) begin
                    m_run[i] = 0; m_frozen[i] = 0; m_pulse[i] = 1;
                end else begin
                    m_run[i] = 1; m_deadline[i] = m_t + v;
                end
            end else if (sp[i]) begin
                if (m_run[i]) begin
                    m_frozen[i] = m_deadline[i] - t_before;
                    m_run[i] = 0;
                end
            end else if (m_run[i] && tick && (m_t == m_deadline[i])) begin
                m_pulse[i] = 1;
                if (m_mode[i]) m_deadline[i] = m_deadline[i] + m_period[i];
                else begin m_run[i] = 0; m_frozen[i] = 0; end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("out[%0d] cyc %0d", i, cyc_num), bus.out[i], m_pulse[i]);
            chk($sformatf("busy[%0d] cyc %0d", i, cyc_num), bus.busy[i], m_run[i]);
            chk($sformatf("count[%0d] cyc %0d", i, cyc_num), bus.count[i*W +: W],
                m_run[i] ? (m_deadline[i] - m_t) : m_frozen[i]);
        end
    endtask

    task automatic cyc(input logic [CH-1:0] st, input logic [CH-1:0] sp,
                       input logic [CH-1:0] per, input logic [CH*W-1:0] lv,
                       input logic ce);
        bus.start = st; bus.stop = sp; bus.periodic = per;
        bus.load_value = lv; bus.count_en = ce;
        @(posedge clk);
        model_step(st, sp, per, lv, ce);
        #1;
        cyc_num++;
        check_all();
        for (int i = 0; i < CH; i++) if (bus.out[i]) pcnt[i]++;
        bus.start = '0; bus.stop = '0; bus.periodic = '0;
        bus.load_value = '0; bus.count_en = 1'b0;
    endtask

    task automatic clear_pcnt();
        for (int i = 0; i < CH; i++) pcnt[i] = 0;
    endtask

    // Idle cycles with a 1-in-6 tick pattern (tick on the last clock of each group).
    task automatic run_slow(input int n_ticks);
        for (int k = 0; k < n_ticks * 6; k++) cyc('0, '0, '0, '0, (k % 6) == 5);
    endtask

    function automatic logic [CH*W-1:0] lv_at(input int ch, input int v);
        logic [CH*W-1:0] r;
        r = '0;
        r[ch*W +: W] = W'(v);
        return r;
    endfunction

    typedef struct {
        logic st, sp, per;
        logic [W-1:0] lv;
        logic ce;
        logic eo, eb;
        logic [W-1:0] ec;
    } vec_t;

    vec_t tbl [19];

    initial begin
        logic [CH*W-1:0] lv;
        logic [CH-1:0]   st, sp, per;
        int              last_pulse, n;

        reset = 1'b1;
        bus.start = '0; bus.stop = '0; bus.periodic = '0;
        bus.load_value = '0; bus.count_en = 1'b0;
        model_reset();
        clear_pcnt();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b0;

`ifndef TIMER_PRESCALE_EN
        // Channel 0 only: {start, stop, periodic, load, count_en, exp out, busy, count}
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 9'd3, 1'b1, 1'b0, 1'b1, 9'd3};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b1, 9'd2};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 9'd2};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b1, 9'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b1, 1'b0, 9'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 9'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 9'd0, 1'b0, 1'b1, 1'b0, 9'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 9'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 9'd1, 1'b0, 1'b0, 1'b1, 9'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b1, 1'b1, 9'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b1, 1'b1, 9'd1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 9'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 9'd1};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 9'd5, 1'b0, 1'b0, 1'b1, 9'd5};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b1, 9'd4};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 9'd2, 1'b1, 1'b0, 1'b1, 9'd2};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b1, 9'd1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b1, 1'b0, 9'd0};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 9'd0};
        for (int r = 0; r < 19; r++) begin
            cyc({3'b000, tbl[r].st}, {3'b000, tbl[r].sp}, {3'b000, tbl[r].per},
                lv_at(0, int'(tbl[r].lv)), tbl[r].ce);
            chk($sformatf("tbl[%0d] out", r), bus.out[0], tbl[r].eo);
            chk($sformatf("tbl[%0d] busy", r), bus.busy[0], tbl[r].eb);
            chk($sformatf("tbl[%0d] count", r), bus.count[W-1:0], tbl[r].ec);
        end
`endif

        // One-shot, load 8, slow ticks: exactly one pulse, then idle at 0.
        clear_pcnt();
        cyc(4'b0001, '0, '0, lv_at(0, 8), 1'b0);
        run_slow(8 * PS);
        chk("oneshot pulses", pcnt[0], 1);
        chk("oneshot busy", bus.busy[0], 0);
        chk("oneshot count", bus.count[W-1:0], 0);
        run_slow(4);
        chk("oneshot no repeat", pcnt[0], 1);

        // Periodic ch1, load 3: 4 pulses over 12 ticks, 18 clocks apart.
        clear_pcnt();
        last_pulse = -1;
        cyc(4'b0010, '0, 4'b0010, lv_at(1, 3), 1'b0);
        for (int k = 0; k < 12 * 6 * PS; k++) begin
            cyc('0, '0, '0, '0, (k % 6) == 5);
            if (bus.out[1]) begin
                if (last_pulse >= 0) chk("periodic spacing", cyc_num - last_pulse, 18 * PS);
                last_pulse = cyc_num;
            end
            if (k > 6 * PS) chk("periodic busy held", bus.busy[1], 1);
        end
        chk("periodic pulses", pcnt[1], 4);
        cyc(4'b0000, 4'b0010, '0, '0, 1'b0);

        // Independence: ch0=4 one-shot, ch2=2 periodic, ch3 stopped at 5.
        clear_pcnt();
        cyc(4'b1101, '0, 4'b0100, lv_at(0, 4) | lv_at(2, 2) | lv_at(3, 5), 1'b0);
        cyc('0, 4'b1000, '0, '0, 1'b0);
        run_slow(8 * PS);
        chk("indep ch0 pulses", pcnt[0], 1);
        chk("indep ch1 pulses", pcnt[1], 0);
        chk("indep ch2 pulses", pcnt[2], 4);
        chk("indep ch3 pulses", pcnt[3], 0);
        chk("indep ch3 frozen", bus.count[3*W +: W], 5);
        cyc('0, 4'b0100, '0, '0, 1'b0);

        // Reset mid-count: everything clears at once, nothing pulses afterwards.
        cyc(4'b0001, '0, '0, lv_at(0, 8), 1'b0);
        for (int k = 0; k < 3; k++) cyc('0, '0, '0, '0, 1'b1);
        reset = 1'b1;
        #2;
        model_reset();
        chk("rst busy", bus.busy, 0);
        chk("rst out", bus.out, 0);
        chk("rst count", bus.count, 0);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
        clear_pcnt();
        for (int k = 0; k < 12; k++) cyc('0, '0, '0, '0, 1'b1);
        chk("no pulse after reset", pcnt[0], 0);

        // Latency in count_en pulses from a freshly reset prescaler, load 2.
        cyc(4'b0001, '0, '0, lv_at(0, 2), 1'b0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            cyc('0, '0, '0, '0, 1'b1);
            n++;
            if (bus.out[0]) break;
        end
        chk("load2 latency", n, 2 * PS);

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < CH; i++) begin
                st[i]  = ($urandom_range(0, 15) == 0);
                sp[i]  = ($urandom_range(0, 31) == 0);
                per[i] = $urandom_range(0, 1) == 1;
                lv[i*W +: W] = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 40))
                                                           : W'($urandom_range(0, 6));
            end
            cyc(st, sp, per, lv, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
